// File: rtl/seg_slave_pkg.sv
// rtl/seg_slave_pkg.sv - shared types and constants for the 7-segment bus slave
package seg_slave_pkg;

    typedef enum logic [2:0] {
        SLV_RAM   = 3'd0,
        SLV_UART  = 3'd1,
        SLV_SEG   = 3'd2,
        SLV_TIMER = 3'd3,
        SLV_NONE  = 3'd7
    } slave_code;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        read;
        logic        write;
        logic [3:0]  dataena;
        logic [3:0]  burstcount;
    } port_transmite_type;

    typedef struct packed {
        logic [31:0] rdata;
        logic        valid;
        logic        waitrequest;
    } port_receive_type;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RBURST = 1'b1
    } seg_state_t;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_CTRL = 2'd1;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_DP_LSB    = 8;
    localparam int CTRL_BLANK_LSB = 16;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_slave_hex7seg.sv
// rtl/seg_slave_hex7seg.sv - hex nibble to active-low segments, out[0]=a .. out[6]=g
module hex7seg (
    input  logic [3:0] hex,
    output logic [6:0] segs
);

    logic [6:0] on;

    always_comb begin
        on = 7'h00;
        case (hex)
            4'h0: on = 7'h3F;
            4'h1: on = 7'h06;
            4'h2: on = 7'h5B;
            4'h3: on = 7'h4F;
            4'h4: on = 7'h66;
            4'h5: on = 7'h6D;
            4'h6: on = 7'h7D;
            4'h7: on = 7'h07;
            4'h8: on = 7'h7F;
            4'h9: on = 7'h6F;
            4'hA: on = 7'h77;
            4'hB: on = 7'h7C;
            4'hC: on = 7'h39;
            4'hD: on = 7'h5E;
            4'hE: on = 7'h79;
            default: on = 7'h71;
        endcase
    end

    assign segs = ~on;

endmodule

// File: rtl/seg_slave.sv
// rtl/seg_slave.sv - bus slave holding DATA/CTRL and scanning a multiplexed 7-segment display
module seg_slave
    import seg_slave_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DIGITS   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  port_transmite_type from_bus,
    input  logic               chsel,
    output port_receive_type   to_bus,
    output logic [7:0]         seg,
    output logic [DIGITS-1:0]  an
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    seg_state_t  state;
    logic [31:0] data_q;
    logic [31:0] ctrl_q;
    logic [3:0]  beat_cnt;
    logic [1:0]  beat_idx;
    logic        valid_q;
    logic        wait_q;
    logic [31:0] rdata_q;

    logic        accept;
    logic [3:0]  bc_eff;
    logic [1:0]  cmd_idx;
    logic [1:0]  wr_idx;
    logic        unused_bus;

    assign accept  = chsel && !wait_q;
    assign bc_eff  = (from_bus.burstcount == 4'd0) ? 4'd1 : from_bus.burstcount;
    assign cmd_idx = from_bus.addr[3:2];
    // A nonzero beat counter in IDLE means a write burst is still running.
    assign wr_idx  = (beat_cnt != 4'd0) ? beat_idx : cmd_idx;
    assign unused_bus = ^{from_bus.addr[31:4], from_bus.addr[1:0]};

    assign to_bus = '{rdata: rdata_q, valid: valid_q, waitrequest: wait_q};

    function automatic logic [31:0] reg_read(input logic [1:0] idx,
                                             input logic [31:0] d,
                                             input logic [31:0] c);
        case (idx)
            REG_DATA: return d;
            REG_CTRL: return c;
            default:  return 32'd0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            data_q   <= 32'd0;
            ctrl_q   <= 32'd0;
            beat_cnt <= 4'd0;
            beat_idx <= 2'd0;
            valid_q  <= 1'b0;
            wait_q   <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            valid_q <= 1'b0;
            rdata_q <= 32'd0;
            case (state)
                ST_IDLE: begin
                    if (accept && from_bus.write) begin
                        if (wr_idx == REG_DATA)
                            data_q <= byte_merge(data_q, from_bus.wdata, from_bus.dataena);
                        else if (wr_idx == REG_CTRL)
                            ctrl_q <= byte_merge(ctrl_q, from_bus.wdata, from_bus.dataena);
                        if (beat_cnt == 4'd0) begin
                            beat_cnt <= bc_eff - 4'd1;
                            beat_idx <= cmd_idx + 2'd1;
                        end else begin
                            beat_cnt <= beat_cnt - 4'd1;
                            beat_idx <= beat_idx + 2'd1;
                        end
                    end else if (accept && from_bus.read) begin
                        valid_q  <= 1'b1;
                        rdata_q  <= reg_read(cmd_idx, data_q, ctrl_q);
                        beat_idx <= cmd_idx + 2'd1;
                        beat_cnt <= bc_eff - 4'd1;
                        if (bc_eff > 4'd1) begin
                            state  <= ST_RBURST;
                            wait_q <= 1'b1;
                        end
                    end
                end
                ST_RBURST: begin
                    valid_q  <= 1'b1;
                    rdata_q  <= reg_read(beat_idx, data_q, ctrl_q);
                    beat_idx <= beat_idx + 2'd1;
                    beat_cnt <= beat_cnt - 4'd1;
                    if (beat_cnt == 4'd1) begin
                        state  <= ST_IDLE;
                        wait_q <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic [PW-1:0] presc;
    logic [DW-1:0] digit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
            digit <= '0;
        end else if (presc == PW'(SCAN_DIV - 1)) begin
            presc <= '0;
            digit <= (digit == DW'(DIGITS - 1)) ? '0 : digit + DW'(1);
        end else begin
            presc <= presc + PW'(1);
        end
    end

    logic [3:0]  nibble;
    logic [6:0]  pattern;
    logic [3:0]  dp_sh;
    logic [3:0]  blank_sh;
    logic        lit;

    // dp and blank fields are 4 bits wide, so DIGITS is expected to be at most 4.
    assign nibble   = 4'(data_q >> (32'(digit) * 32'd4));
    assign dp_sh    = ctrl_q[CTRL_DP_LSB +: 4] >> digit;
    assign blank_sh = ctrl_q[CTRL_BLANK_LSB +: 4] >> digit;
    assign lit      = ctrl_q[CTRL_EN_BIT] && !blank_sh[0];

    hex7seg u_hex7seg (
        .hex  (nibble),
        .segs (pattern)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg <= 8'hFF;
            an  <= '1;
        end else if (lit) begin
            seg <= {~dp_sh[0], pattern};
            an  <= ~(DIGITS'(1) << digit);
        end else begin
            seg <= 8'hFF;
            an  <= '1;
        end
    end

endmodule

// File: tb/tb_seg_slave.sv
// tb/tb_seg_slave.sv - directed self-checking bench for seg_slave
module tb_seg_slave;
    import seg_slave_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    port_transmite_type from_bus;
    logic               chsel;
    port_receive_type   to_bus;
    logic [7:0]         seg;
    logic [3:0]         an;

    int n_vec = 0;
    int n_bad = 0;

    seg_slave #(.SCAN_DIV(4), .DIGITS(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .from_bus (from_bus),
        .chsel    (chsel),
        .to_bus   (to_bus),
        .seg      (seg),
        .an       (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        from_bus = '0;
        chsel    = 1'b0;
    endtask

    task automatic bus_cmd(input logic [1:0] idx, input logic [31:0] d, input logic rd,
                           input logic wr, input logic [3:0] be, input logic [3:0] bc);
        from_bus = '{addr: {28'd0, idx, 2'b00}, wdata: d, read: rd, write: wr,
                     dataena: be, burstcount: bc};
        chsel = 1'b1;
    endtask

    task automatic bus_wr(input logic [1:0] idx, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        bus_cmd(idx, d, 1'b0, 1'b1, be, 4'd1);
        @(negedge clk);
        bus_idle();
    endtask

    task automatic bus_rd(input string tag, input logic [1:0] idx, input logic [3:0] bc,
                          input logic [31:0] exp);
        @(negedge clk);
        bus_cmd(idx, 32'd0, 1'b1, 1'b0, 4'h0, bc);
        @(negedge clk);
        bus_idle();
        check({tag, "_valid"}, {31'd0, to_bus.valid}, 32'd1);
        check({tag, "_rdata"}, to_bus.rdata, exp);
    endtask

    logic [3:0] exp_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] exp_seg[4] = '{8'hF9, 8'hA4, 8'hB0, 8'h99};

    initial begin
        int cnt;
        int vcnt;
        logic [3:0] prev;
        bus_idle();
        repeat (3) @(negedge clk);
        check("rst_valid", {31'd0, to_bus.valid}, 32'd0);
        check("rst_wait", {31'd0, to_bus.waitrequest}, 32'd0);
        check("rst_rdata", to_bus.rdata, 32'd0);
        check("rst_seg", {24'd0, seg}, 32'h0000_00FF);
        check("rst_an", {28'd0, an}, 32'h0000_000F);
        rst_n = 1'b1;

        bus_wr(2'd0, 32'h0000_1234, 4'hF);
        bus_rd("rd_data", 2'd0, 4'd1, 32'h0000_1234);
        @(negedge clk);
        check("rd_single_done", {31'd0, to_bus.valid}, 32'd0);
        check("idle_rdata_zero", to_bus.rdata, 32'd0);

        bus_wr(2'd0, 32'hAABB_CCDD, 4'hF);
        bus_wr(2'd0, 32'h0000_0011, 4'b0001);
        bus_rd("rd_bytemask", 2'd0, 4'd0, 32'hAABB_CC11);
        @(negedge clk);
        check("bc0_one_beat", {31'd0, to_bus.valid}, 32'd0);

        bus_wr(2'd3, 32'hDEAD_BEEF, 4'hF);
        bus_rd("rd_unmapped", 2'd3, 4'd1, 32'd0);
        bus_rd("rd_after_unmapped_wr", 2'd0, 4'd1, 32'hAABB_CC11);

        // read and write together: write wins, no response
        @(negedge clk);
        bus_cmd(2'd1, 32'h0000_0B00, 1'b1, 1'b1, 4'hF, 4'd1);
        @(negedge clk);
        bus_idle();
        check("rw_no_valid", {31'd0, to_bus.valid}, 32'd0);
        bus_rd("rw_ctrl", 2'd1, 4'd1, 32'h0000_0B00);

        // two-beat write burst starting at DATA
        @(negedge clk);
        bus_cmd(2'd0, 32'h5566_7788, 1'b0, 1'b1, 4'hF, 4'd2);
        @(negedge clk);
        check("wburst_wait", {31'd0, to_bus.waitrequest}, 32'd0);
        bus_cmd(2'd0, 32'h0000_0A00, 1'b0, 1'b1, 4'hF, 4'd2);
        @(negedge clk);
        bus_idle();

        @(negedge clk);
        bus_cmd(2'd0, 32'd0, 1'b1, 1'b0, 4'h0, 4'd3);
        @(negedge clk);
        bus_idle();
        check("rb0_valid", {31'd0, to_bus.valid}, 32'd1);
        check("rb0_data", to_bus.rdata, 32'h5566_7788);
        check("rb0_wait", {31'd0, to_bus.waitrequest}, 32'd1);
        @(negedge clk);
        check("rb1_valid", {31'd0, to_bus.valid}, 32'd1);
        check("rb1_data", to_bus.rdata, 32'h0000_0A00);
        check("rb1_wait", {31'd0, to_bus.waitrequest}, 32'd1);
        @(negedge clk);
        check("rb2_valid", {31'd0, to_bus.valid}, 32'd1);
        check("rb2_data", to_bus.rdata, 32'd0);
        @(negedge clk);
        check("rb_end_valid", {31'd0, to_bus.valid}, 32'd0);
        check("rb_end_wait", {31'd0, to_bus.waitrequest}, 32'd0);

        bus_wr(2'd0, 32'h0000_4321, 4'hF);
        bus_wr(2'd1, 32'h0000_0001, 4'hF);
        cnt = 0;
        while (an != 4'b0111 && cnt < 40) begin @(negedge clk); cnt++; end
        check("scan_sync", {31'd0, cnt < 40}, 32'd1);
        cnt = 0;
        while (an == 4'b0111 && cnt < 20) begin @(negedge clk); cnt++; end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("scan_an%0d", k), {28'd0, an}, {28'd0, exp_an[k]});
            check($sformatf("scan_seg%0d", k), {24'd0, seg}, {24'd0, exp_seg[k]});
            prev = an;
            cnt = 0;
            while (an == prev && cnt < 20) begin @(negedge clk); cnt++; end
            check($sformatf("scan_dwell%0d", k), cnt, 32'd4);
        end
        check("scan_wrap", {28'd0, an}, 32'h0000_000E);

        // reset in the middle of a four-beat read burst
        @(negedge clk);
        bus_cmd(2'd0, 32'd0, 1'b1, 1'b0, 4'h0, 4'd4);
        @(negedge clk);
        bus_idle();
        check("rst_b0_data", to_bus.rdata, 32'h0000_4321);
        @(negedge clk);
        check("rst_b1_data", to_bus.rdata, 32'h0000_0001);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_valid", {31'd0, to_bus.valid}, 32'd0);
        check("abort_wait", {31'd0, to_bus.waitrequest}, 32'd0);
        check("abort_seg", {24'd0, seg}, 32'h0000_00FF);
        check("abort_an", {28'd0, an}, 32'h0000_000F);
        rst_n = 1'b1;
        vcnt = 0;
        repeat (4) begin @(negedge clk); vcnt += int'(to_bus.valid); end
        check("abort_no_beats", vcnt, 32'd0);
        bus_rd("rst_cleared_data", 2'd0, 4'd1, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_slave.md
SEG_SLAVE -- requirements
Module: seg_slave

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clk cycles per digit-scan step.
REQ-002 SHALL have parameter DIGITS, default 4, meaning number of 7-segment digits driven.
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset, synchronous and active-low.
REQ-005 SHALL have port from_bus, input, port_transmite_type (addr 32, wdata 32, read 1, write 1, dataena 4, burstcount 4), meaning shared bus request.
REQ-006 SHALL have port chsel, input, 1, meaning this slave is selected (seg_chsel).
REQ-007 SHALL have port to_bus, output, port_receive_type (rdata 32, valid 1, waitrequest 1), meaning response to the bus mux.
REQ-008 SHALL have port seg, output, 8, meaning segments a-g plus dp, active-low.
REQ-009 SHALL have port an, output, DIGITS, meaning digit anodes, active-low, one-hot-low.

Function
REQ-010 SHALL decode word index = from_bus.addr[3:2]: 0 = DATA (one nibble per digit, digit 0 = bits 3:0), 1 = CTRL (bit0 enable, bits 11:8 dp per digit, bits 19:16 blank mask per digit), 2-3 unmapped.
REQ-011 SHALL accept a command only when chsel=1 and to_bus.waitrequest=0.
REQ-012 SHALL, on an accepted write, update each byte i of the addressed register where dataena[i]=1, in the same cycle; bytes with dataena[i]=0 unchanged.
REQ-013 SHALL ignore writes to unmapped indices, with no response.
REQ-014 SHALL, for an accepted read, drive to_bus.valid=1 with rdata exactly one cycle later (fixed read latency 1); unmapped indices return 0.
REQ-015 SHALL treat burstcount 0 as 1.
REQ-016 SHALL use FSM IDLE/RBURST: read with burstcount N>1 enters RBURST, returns N valid beats on N consecutive cycles, word index incrementing modulo 4 from the start index, then returns to IDLE.
REQ-017 SHALL hold waitrequest=1 while in RBURST, and waitrequest=0 in IDLE.
REQ-018 SHALL accept write bursts one beat per cycle with waitrequest=0, word index incrementing modulo 4 per beat, tracked by a beat counter reloaded on the first beat.
REQ-019 SHALL, with read and write both asserted, perform the write and ignore the read (no valid).
REQ-020 SHALL keep valid=0 and rdata=0 in every cycle not carrying a read beat.
REQ-021 SHALL advance a prescaler 0..SCAN_DIV-1 and, on its wrap, a digit counter 0..DIGITS-1 with wrap to 0.
REQ-022 SHALL drive an with only bit [digit counter] low when CTRL.enable=1 and that digit's blank bit=0, otherwise all ones.
REQ-023 SHALL drive seg with the hex-decoded nibble of the current digit, dp = CTRL.dp[digit], active-low; seg=8'hFF when that digit is blanked or disabled.
REQ-024 SHALL register seg and an (one-cycle delay from counter/register change).

Reset
REQ-025 SHALL, with rst_n=0 at a clock edge, set DATA=0, CTRL=0, FSM=IDLE, beat counter=0, prescaler=0, digit counter=0, valid=0, waitrequest=0, rdata=0, seg=8'hFF, an all ones.
REQ-026 SHALL abort any burst in progress on reset, with no further valid beats after reset.

Structure
REQ-027 SHALL place the FSM state enum, register index constants and CTRL bit-field constants in the shared package alongside slave_code.
REQ-028 SHALL implement hex-to-segment decode as sub-module hex7seg (4-bit in, 7-bit active-low out, combinational).

Verification
REQ-029 SHALL test: write DATA=32'h0000_1234, dataena=4'hF, then read index 0 -> valid one cycle after accept, rdata=32'h0000_1234.
REQ-030 SHALL test: write 32'hAABB_CCDD then 32'h0000_0011 with dataena=4'b0001 -> read returns 32'hAABB_CC11.
REQ-031 SHALL test: read burst burstcount=3 from index 0 -> waitrequest=1 during burst, beats DATA, CTRL, 0 on consecutive cycles.
REQ-032 SHALL test: CTRL=32'h0000_0001, DATA=32'h0000_4321, SCAN_DIV=4 -> an cycles 1110,1101,1011,0111 every 4 clocks, seg shows 1,2,3,4.
REQ-033 SHALL test: rst_n=0 during 4-beat read burst after beat 2 -> no further valid, waitrequest=0, seg=8'hFF, an all ones.
REQ-034 SHALL test: read and write asserted together at index 1 -> CTRL updated, valid stays 0.
